// File: rtl/dsp_div.sv
// Sequential radix-2 restoring divider: 32-bit unsigned, 32-bit signed, and dual 16-bit unsigned lanes.
// One quotient bit per lane per cycle; results are returned over a valid/ready response channel.
module dsp_div (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_command,
  input  logic [31:0] req_in_1,
  input  logic [31:0] req_in_2,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_result,
  output logic [1:0]  dbg_state
);

  // Handshake: a channel transfers on a rising edge where valid and ready are both 1;
  // a valid response holds its data stable until it transfers.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;
  typedef enum logic [1:0] {M_U32 = 2'd0, M_S32 = 2'd1, M_U16X2 = 2'd2} mode_t;

  state_t      r_state, w_state_nxt;
  mode_t       r_mode, w_mode_req;
  logic [4:0]  r_cnt;
  logic [31:0] r_dvd, r_dvs, r_rem;
  logic        r_qneg, r_rneg, r_z0, r_z1;
  logic [63:0] r_result;

  logic [31:0] w_abs1, w_abs2;
  logic        w_z0_req, w_z1_req;
  logic [32:0] w_p32;
  logic [16:0] w_p1, w_p0;
  logic        w_ge32, w_ge1, w_ge0;
  logic [31:0] w_rem32, w_rem_nxt, w_dvd_nxt, w_quo_fix, w_rem_fix;
  logic [15:0] w_rem1, w_rem0;

  // Request decode: unknown commands run as unsigned 32/32.
  always_comb begin
    w_mode_req = M_U32;
    if (req_command == 32'd1)      w_mode_req = M_S32;
    else if (req_command == 32'd2) w_mode_req = M_U16X2;
    w_abs1 = (w_mode_req == M_S32 && req_in_1[31]) ? (~req_in_1 + 32'd1) : req_in_1;
    w_abs2 = (w_mode_req == M_S32 && req_in_2[31]) ? (~req_in_2 + 32'd1) : req_in_2;
    if (w_mode_req == M_U16X2) begin
      w_z0_req = (req_in_2[15:0] == 16'd0);
      w_z1_req = (req_in_2[31:16] == 16'd0);
    end else begin
      w_z0_req = (req_in_2 == 32'd0);
      w_z1_req = w_z0_req;
    end
  end

  // One restoring step; the subtracted result always fits the divisor width.
  always_comb begin
    w_p32   = {r_rem, r_dvd[31]};
    w_ge32  = (w_p32 >= {1'b0, r_dvs});
    w_rem32 = w_ge32 ? (w_p32[31:0] - r_dvs) : w_p32[31:0];
    w_p1    = {r_rem[31:16], r_dvd[31]};
    w_ge1   = (w_p1 >= {1'b0, r_dvs[31:16]});
    w_rem1  = w_ge1 ? (w_p1[15:0] - r_dvs[31:16]) : w_p1[15:0];
    w_p0    = {r_rem[15:0], r_dvd[15]};
    w_ge0   = (w_p0 >= {1'b0, r_dvs[15:0]});
    w_rem0  = w_ge0 ? (w_p0[15:0] - r_dvs[15:0]) : w_p0[15:0];
    if (r_mode == M_U16X2) begin
      w_rem_nxt = {w_rem1, w_rem0};
      w_dvd_nxt = {r_dvd[30:16], w_ge1, r_dvd[14:0], w_ge0};
    end else begin
      w_rem_nxt = w_rem32;
      w_dvd_nxt = {r_dvd[30:0], w_ge32};
    end
  end

  // Sign fix-up; a zero divisor forces an all-ones quotient regardless of sign.
  always_comb begin
    w_quo_fix = r_qneg ? (~w_dvd_nxt + 32'd1) : w_dvd_nxt;
    w_rem_fix = r_rneg ? (~w_rem_nxt + 32'd1) : w_rem_nxt;
    if (r_z1) w_quo_fix[31:16] = 16'hFFFF;
    if (r_z0) w_quo_fix[15:0]  = 16'hFFFF;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_state_nxt = S_BUSY;
      S_BUSY:  if (r_cnt == 5'd0) w_state_nxt = S_DONE;
      S_DONE:  if (resp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode   <= M_U32;
      r_cnt    <= 5'd0;
      r_dvd    <= 32'd0;
      r_dvs    <= 32'd0;
      r_rem    <= 32'd0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_z0     <= 1'b0;
      r_z1     <= 1'b0;
      r_result <= 64'd0;
    end else if (r_state == S_IDLE && req_valid) begin
      r_mode <= w_mode_req;
      r_cnt  <= (w_mode_req == M_U16X2) ? 5'd15 : 5'd31;
      r_dvd  <= w_abs1;
      r_dvs  <= w_abs2;
      r_rem  <= 32'd0;
      r_qneg <= (w_mode_req == M_S32) && (req_in_1[31] ^ req_in_2[31]);
      r_rneg <= (w_mode_req == M_S32) && req_in_1[31];
      r_z0   <= w_z0_req;
      r_z1   <= w_z1_req;
    end else if (r_state == S_BUSY) begin
      r_rem <= w_rem_nxt;
      r_dvd <= w_dvd_nxt;
      if (r_cnt == 5'd0) r_result <= {w_rem_fix, w_quo_fix};
      else               r_cnt    <= r_cnt - 5'd1;
    end
  end

  assign req_ready   = (r_state == S_IDLE);
  assign resp_valid  = (r_state == S_DONE);
  assign resp_result = r_result;
  assign dbg_state   = r_state;

endmodule
